// File: rtl/frame_stream_ctrl_pkg.sv
// Shared types and constants for the Frotaegis frame-to-stream sequencer.
package frotaegis_pkg;

  localparam int unsigned AXIS_W     = 32;
  localparam logic [3:0]  AXIS_TKEEP = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } fsm_state_e;

  // A new read may issue when buffered + in-flight entries, less this cycle's
  // pop, leave room in the 2-entry skid buffer.
  function automatic logic read_credit(input logic [1:0] count,
                                       input logic       inflight,
                                       input logic       pop);
    return ({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
  endfunction

endpackage

// File: rtl/frame_stream_ctrl_if.sv
// AXI-Stream S2MM link carrying frame samples to the PS DMA.
interface frame_stream_ctrl_if;

  logic [frotaegis_pkg::AXIS_W-1:0] tdata;
  logic [3:0]                       tkeep;
  logic                             tlast;
  logic                             tvalid;
  logic                             tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);

endinterface

// File: rtl/frame_stream_ctrl_skid.sv
// Two-entry FIFO holding {last, sample} between the frame buffer read return
// and the stream handshake.
module axis_skid_buf #(
  parameter int unsigned W = 13
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_pop;

  assign do_pop = pop_i && (count_q != 2'd0);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = ~wr_ptr_q;
    if (do_pop) rd_ptr_d = ~rd_ptr_q;
    if (push_i && !do_pop) count_d = count_q + 2'd1;
    else if (!push_i && do_pop) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    push_i |-> (count_q != 2'd2) || do_pop);

endmodule

// File: rtl/frame_stream_ctrl.sv
// Streams LENGTH-sample frames from the frame buffer onto AXI-Stream S2MM,
// single-shot or gapless continuous, with credit-based read issue.
module frame_stream_ctrl
  import frotaegis_pkg::*;
#(
  parameter int unsigned DATA_SIZE   = 12,
  parameter int unsigned LENGTH      = 32768,
  parameter int unsigned LENGTH_SIZE = 15
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   Start,
  input  logic                   Stop,
  input  logic                   Cont,
  output logic                   Busy,
  output logic                   Done,
  output logic [15:0]            FrameCnt,
  output logic                   RdEn,
  output logic [LENGTH_SIZE-1:0] RdAdd,
  input  logic [DATA_SIZE-1:0]   RdData,
  frame_stream_ctrl_if.master    M_AXIS
);

  localparam logic [LENGTH_SIZE-1:0] LAST_IDX = LENGTH_SIZE'(LENGTH - 1);

  fsm_state_e             state_q, state_d;
  logic [LENGTH_SIZE-1:0] idx_q, idx_d;
  logic                   cont_q, cont_d;
  logic                   stop_q, stop_d;
  logic                   inflight_q, inflight_last_q;
  logic                   done_q;
  logic [15:0]            frame_cnt_q, frame_cnt_d;

  logic                   rd_en;
  logic [1:0]             buf_count;
  logic [DATA_SIZE:0]     head;
  logic [DATA_SIZE-1:0]   head_data;
  logic                   head_last;
  logic                   pop;
  logic                   last_pop;

  assign {head_last, head_data} = head;
  assign pop      = (buf_count != 2'd0) && M_AXIS.tready;
  assign last_pop = pop && head_last;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cont_d      = cont_q;
    stop_d      = stop_q;
    rd_en       = 1'b0;
    frame_cnt_d = last_pop ? frame_cnt_q + 16'd1 : frame_cnt_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          cont_d  = Cont;
          stop_d  = 1'b0;
          idx_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (Stop) stop_d = 1'b1;
        if (read_credit(buf_count, inflight_q, pop)) begin
          rd_en = 1'b1;
          // Wrap decision uses the registered stop so a Stop landing on the
          // final read still lets the already-committed next frame run.
          if (idx_q == LAST_IDX) begin
            if (cont_q && !stop_q) idx_d = '0;
            else                   state_d = FLUSH;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (Stop) stop_d = 1'b1;
        if (last_pop && (buf_count == 2'd1) && !inflight_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      cont_q          <= 1'b0;
      stop_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
      frame_cnt_q     <= '0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      cont_q          <= cont_d;
      stop_q          <= stop_d;
      inflight_q      <= rd_en;
      inflight_last_q <= rd_en && (idx_q == LAST_IDX);
      done_q          <= last_pop;
      frame_cnt_q     <= frame_cnt_d;
    end
  end

  axis_skid_buf #(
    .W (DATA_SIZE + 1)
  ) u_skid (
    .clk         (clk),
    .rstn        (rstn),
    .push_i      (inflight_q),
    .push_data_i ({inflight_last_q, RdData}),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (buf_count)
  );

  assign Busy          = (state_q != IDLE);
  assign Done          = done_q;
  assign FrameCnt      = frame_cnt_q;
  assign RdEn          = rd_en;
  assign RdAdd         = idx_q;
  assign M_AXIS.tvalid = (buf_count != 2'd0);
  assign M_AXIS.tdata  = {{(AXIS_W - DATA_SIZE){1'b0}}, head_data};
  assign M_AXIS.tlast  = head_last;
  assign M_AXIS.tkeep  = AXIS_TKEEP;

  a_axis_hold: assert property (@(posedge clk) disable iff (!rstn)
    M_AXIS.tvalid && !M_AXIS.tready |=>
      M_AXIS.tvalid && $stable(M_AXIS.tdata) && $stable(M_AXIS.tlast));

endmodule

// File: tb/tb_frame_stream_ctrl.sv
// Bench for frame_stream_ctrl: small frames, buffer model RdData = RdAdd[3:0].
module tb_frame_stream_ctrl;

  localparam int unsigned DATA_SIZE   = 4;
  localparam int unsigned LENGTH      = 256;
  localparam int unsigned LENGTH_SIZE = 8;

  logic                   clk   = 1'b0;
  logic                   rstn  = 1'b0;
  logic                   Start = 1'b0;
  logic                   Stop  = 1'b0;
  logic                   Cont  = 1'b0;
  logic                   Busy;
  logic                   Done;
  logic [15:0]            FrameCnt;
  logic                   RdEn;
  logic [LENGTH_SIZE-1:0] RdAdd;
  logic [DATA_SIZE-1:0]   RdData = '0;

  frame_stream_ctrl_if axis ();

  frame_stream_ctrl #(
    .DATA_SIZE   (DATA_SIZE),
    .LENGTH      (LENGTH),
    .LENGTH_SIZE (LENGTH_SIZE)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .Start    (Start),
    .Stop     (Stop),
    .Cont     (Cont),
    .Busy     (Busy),
    .Done     (Done),
    .FrameCnt (FrameCnt),
    .RdEn     (RdEn),
    .RdAdd    (RdAdd),
    .RdData   (RdData),
    .M_AXIS   (axis)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (RdEn) RdData <= RdAdd[3:0];

  int errors = 0;
  int checks = 0;
  int unsigned exp_frames = 0;

  // Observation log, sampled on the falling edge.
  int unsigned cyc = 0;
  logic [31:0] got_data[$];
  logic        got_last[$];
  int unsigned got_cyc[$];
  int unsigned done_cyc[$];
  int          rden_cnt = 0;
  int          viol = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (axis.tvalid !== 1'b1 || axis.tdata !== prev_data || axis.tlast !== prev_last))
        viol++;
      if (axis.tvalid && axis.tready) begin
        got_data.push_back(axis.tdata);
        got_last.push_back(axis.tlast);
        got_cyc.push_back(cyc);
      end
      if (Done) done_cyc.push_back(cyc);
      if (RdEn) rden_cnt++;
      prev_stall = axis.tvalid & !axis.tready;
      prev_data  = axis.tdata;
      prev_last  = axis.tlast;
    end
  end

  // Reference model: frame k beat i carries sample i mod 16, last on i == LENGTH-1.
  logic [31:0] exp_data[$];
  logic        exp_last[$];

  task automatic model_frames(input int nframes);
    exp_data.delete();
    exp_last.delete();
    for (int f = 0; f < nframes; f++)
      for (int i = 0; i < int'(LENGTH); i++) begin
        exp_data.push_back(32'(i % 16));
        exp_last.push_back(i == int'(LENGTH) - 1);
      end
  endtask

  task automatic clear_mon();
    got_data.delete();
    got_last.delete();
    got_cyc.delete();
    done_cyc.delete();
    rden_cnt = 0;
    viol = 0;
  endtask

  task automatic begin_frame(input logic cont, input logic stop);
    Cont  = cont;
    Start = 1'b1;
    Stop  = stop;
    @(posedge clk); #1;
    Start = 1'b0;
    Stop  = 1'b0;
  endtask

  // mode 0: tready=1, 1: toggles 1,0,..., 2: random (75% ready).
  task automatic drive_until_idle(input int mode, input int budget, input int stop_at,
                                  input int start_at, output bit timed_out);
    bit stop_sent = 1'b0;
    bit start_sent = 1'b0;
    timed_out = 1'b1;
    for (int n = 0; n < budget; n++) begin
      case (mode)
        0:       axis.tready = 1'b1;
        1:       axis.tready = (n % 2 == 0);
        default: axis.tready = ($urandom_range(3) != 0);
      endcase
      Stop  = 1'b0;
      Start = 1'b0;
      if (stop_at >= 0 && !stop_sent && got_data.size() >= stop_at) begin
        Stop = 1'b1;
        stop_sent = 1'b1;
      end
      if (start_at >= 0 && !start_sent && got_data.size() >= start_at) begin
        Start = 1'b1;
        start_sent = 1'b1;
      end
      @(posedge clk); #1;
      if (!Busy) begin
        timed_out = 1'b0;
        break;
      end
    end
    Stop = 1'b0;
    Start = 1'b0;
    axis.tready = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    axis.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({Busy, Done, RdEn, axis.tvalid, axis.tlast} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got Busy/Done/RdEn/tvalid/tlast=%b required 00000",
               {Busy, Done, RdEn, axis.tvalid, axis.tlast});
    end
    checks++;
    if (FrameCnt !== 16'd0 || RdAdd !== '0 || axis.tdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_values: got FrameCnt=%0d RdAdd=%0d tdata=%0h required 0 0 0",
               FrameCnt, RdAdd, axis.tdata);
    end
    checks++;
    if (axis.tkeep !== 4'hF) begin
      errors++;
      $display("FAIL reset_tkeep: got %h required f", axis.tkeep);
    end
    rstn = 1'b1;
    exp_frames = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_frame();
    bit to;
    clear_mon();
    model_frames(1);
    axis.tready = 1'b1;
    begin_frame(1'b0, 1'b0);
    checks++;
    if (Busy !== 1'b1 || RdEn !== 1'b1 || RdAdd !== '0) begin
      errors++;
      $display("FAIL single_cycle1: got Busy=%b RdEn=%b RdAdd=%0d required 1 1 0", Busy, RdEn, RdAdd);
    end
    @(posedge clk); #1;
    checks++;
    if (axis.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL single_cycle2_tvalid: got %b required 0", axis.tvalid);
    end
    @(posedge clk); #1;
    checks++;
    if (axis.tvalid !== 1'b1 || axis.tdata !== 32'd0) begin
      errors++;
      $display("FAIL single_cycle3: got tvalid=%b tdata=%0h required 1 0", axis.tvalid, axis.tdata);
    end
    drive_until_idle(0, 2000, -1, -1, to);
    checks++;
    if (to) begin errors++; $display("FAIL single_timeout: got busy after 2000 cycles required idle"); end
    repeat (2) @(posedge clk);
    #1;
    exp_frames++;
    checks++;
    if (got_data.size() != exp_data.size()) begin
      errors++;
      $display("FAIL single_count: got %0d beats required %0d", got_data.size(), exp_data.size());
    end
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i] || got_cyc[i] !== got_cyc[0] + i) begin
        errors++;
        $display("FAIL single_beat %0d: got data=%0h last=%b gap=%0d required data=%0h last=%b gap=%0d",
                 i, got_data[i], got_last[i], got_cyc[i] - got_cyc[0], exp_data[i], exp_last[i], i);
      end
    end
    checks++;
    if (done_cyc.size() != 1 || (got_cyc.size() > 0 && done_cyc.size() > 0 && done_cyc[0] !== got_cyc[got_cyc.size()-1] + 1)) begin
      errors++;
      $display("FAIL single_done: got %0d pulses required 1 in cycle after tlast", done_cyc.size());
    end
    checks++;
    if (FrameCnt !== 16'(exp_frames) || Busy !== 1'b0) begin
      errors++;
      $display("FAIL single_end: got FrameCnt=%0d Busy=%b required %0d 0", FrameCnt, Busy, exp_frames);
    end
  endtask

  task automatic test_backpressure(input int mode, input string name);
    bit to;
    clear_mon();
    model_frames(1);
    begin_frame(1'b0, 1'b0);
    drive_until_idle(mode, 4000, -1, -1, to);
    checks++;
    if (to) begin errors++; $display("FAIL %s_timeout: got busy after 4000 cycles required idle", name); end
    repeat (2) @(posedge clk);
    #1;
    exp_frames++;
    checks++;
    if (got_data.size() != exp_data.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d beats required %0d", name, got_data.size(), exp_data.size());
    end
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        errors++;
        $display("FAIL %s_beat %0d: got data=%0h last=%b required data=%0h last=%b",
                 name, i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      end
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL %s_stall_hold: got %0d unstable stall cycles required 0", name, viol);
    end
    checks++;
    if (done_cyc.size() != 1 || FrameCnt !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL %s_done: got pulses=%0d FrameCnt=%0d required 1 %0d", name, done_cyc.size(), FrameCnt, exp_frames);
    end
  endtask

  task automatic test_stall_50();
    bit to;
    clear_mon();
    model_frames(1);
    axis.tready = 1'b0;
    begin_frame(1'b0, 1'b0);
    repeat (50) @(posedge clk);
    #1;
    checks++;
    if (rden_cnt != 2) begin
      errors++;
      $display("FAIL stall_reads: got %0d RdEn pulses required 2", rden_cnt);
    end
    checks++;
    if (axis.tvalid !== 1'b1 || axis.tdata !== 32'd0 || axis.tlast !== 1'b0 || got_data.size() != 0) begin
      errors++;
      $display("FAIL stall_hold: got tvalid=%b tdata=%0h tlast=%b beats=%0d required 1 0 0 0",
               axis.tvalid, axis.tdata, axis.tlast, got_data.size());
    end
    drive_until_idle(0, 2000, -1, -1, to);
    checks++;
    if (to) begin errors++; $display("FAIL stall_timeout: got busy after 2000 cycles required idle"); end
    repeat (2) @(posedge clk);
    #1;
    exp_frames++;
    checks++;
    if (got_data.size() != exp_data.size()) begin
      errors++;
      $display("FAIL stall_count: got %0d beats required %0d", got_data.size(), exp_data.size());
    end
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i] || got_cyc[i] !== got_cyc[0] + i) begin
        errors++;
        $display("FAIL stall_beat %0d: got data=%0h last=%b gap=%0d required data=%0h last=%b gap=%0d",
                 i, got_data[i], got_last[i], got_cyc[i] - got_cyc[0], exp_data[i], exp_last[i], i);
      end
    end
    checks++;
    if (FrameCnt !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL stall_framecnt: got %0d required %0d", FrameCnt, exp_frames);
    end
  endtask

  // start_stop: assert Stop together with Start (Start must win, Stop cleared).
  task automatic test_continuous(input logic start_stop, input int stop_at, input string name);
    bit to;
    int unsigned exp_last_idx[2];
    clear_mon();
    model_frames(2);
    begin_frame(1'b1, start_stop);
    drive_until_idle(0, 3000, stop_at, -1, to);
    checks++;
    if (to) begin errors++; $display("FAIL %s_timeout: got busy after 3000 cycles required idle", name); end
    repeat (2) @(posedge clk);
    #1;
    exp_frames += 2;
    checks++;
    if (got_data.size() != exp_data.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d beats required %0d", name, got_data.size(), exp_data.size());
    end
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i] || got_cyc[i] !== got_cyc[0] + i) begin
        errors++;
        $display("FAIL %s_beat %0d: got data=%0h last=%b gap=%0d required data=%0h last=%b gap=%0d",
                 name, i, got_data[i], got_last[i], got_cyc[i] - got_cyc[0], exp_data[i], exp_last[i], i);
      end
    end
    exp_last_idx[0] = LENGTH - 1;
    exp_last_idx[1] = 2 * LENGTH - 1;
    checks++;
    if (done_cyc.size() != 2) begin
      errors++;
      $display("FAIL %s_done_count: got %0d pulses required 2", name, done_cyc.size());
    end else if (got_cyc.size() == 2 * LENGTH) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (done_cyc[k] !== got_cyc[exp_last_idx[k]] + 1) begin
          errors++;
          $display("FAIL %s_done_time %0d: got cycle %0d required %0d", name, k, done_cyc[k], got_cyc[exp_last_idx[k]] + 1);
        end
      end
    end
    checks++;
    if (FrameCnt !== 16'(exp_frames) || Busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_end: got FrameCnt=%0d Busy=%b required %0d 0", name, FrameCnt, Busy, exp_frames);
    end
  endtask

  task automatic test_start_ignored();
    bit to;
    clear_mon();
    model_frames(1);
    begin_frame(1'b0, 1'b0);
    Cont = 1'b1;
    drive_until_idle(0, 2000, -1, 100, to);
    Cont = 1'b0;
    checks++;
    if (to) begin errors++; $display("FAIL restart_timeout: got busy after 2000 cycles required idle"); end
    repeat (2) @(posedge clk);
    #1;
    exp_frames++;
    checks++;
    if (got_data.size() != exp_data.size()) begin
      errors++;
      $display("FAIL restart_count: got %0d beats required %0d", got_data.size(), exp_data.size());
    end
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        errors++;
        $display("FAIL restart_beat %0d: got data=%0h last=%b required data=%0h last=%b",
                 i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      end
    end
    checks++;
    if (done_cyc.size() != 1 || FrameCnt !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL restart_done: got pulses=%0d FrameCnt=%0d required 1 %0d", done_cyc.size(), FrameCnt, exp_frames);
    end
  endtask

  task automatic test_reset_midframe();
    bit to;
    bit reached = 1'b0;
    clear_mon();
    begin_frame(1'b0, 1'b0);
    for (int n = 0; n < 500; n++) begin
      if (got_data.size() >= 77) begin reached = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!reached) begin errors++; $display("FAIL midreset_reach: got %0d beats required 77", got_data.size()); end
    rstn = 1'b0;
    #1;
    checks++;
    if ({Busy, Done, RdEn, axis.tvalid, axis.tlast} !== 5'b0 || FrameCnt !== 16'd0 ||
        RdAdd !== '0 || axis.tdata !== 32'd0 || axis.tkeep !== 4'hF) begin
      errors++;
      $display("FAIL midreset_outputs: got Busy=%b Done=%b RdEn=%b tvalid=%b tlast=%b FrameCnt=%0d RdAdd=%0d tdata=%0h tkeep=%h required all 0, tkeep f",
               Busy, Done, RdEn, axis.tvalid, axis.tlast, FrameCnt, RdAdd, axis.tdata, axis.tkeep);
    end
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    exp_frames = 0;
    @(posedge clk); #1;
    clear_mon();
    model_frames(1);
    begin_frame(1'b0, 1'b0);
    checks++;
    if (RdEn !== 1'b1 || RdAdd !== '0) begin
      errors++;
      $display("FAIL midreset_restart: got RdEn=%b RdAdd=%0d required 1 0", RdEn, RdAdd);
    end
    drive_until_idle(2, 3000, -1, -1, to);
    checks++;
    if (to) begin errors++; $display("FAIL midreset_timeout: got busy after 3000 cycles required idle"); end
    repeat (2) @(posedge clk);
    #1;
    exp_frames++;
    checks++;
    if (got_data.size() != exp_data.size()) begin
      errors++;
      $display("FAIL midreset_count: got %0d beats required %0d", got_data.size(), exp_data.size());
    end
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        errors++;
        $display("FAIL midreset_beat %0d: got data=%0h last=%b required data=%0h last=%b",
                 i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      end
    end
    checks++;
    if (FrameCnt !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL midreset_framecnt: got %0d required %0d", FrameCnt, exp_frames);
    end
  endtask

  initial begin
    axis.tready = 1'b1;
    test_reset();
    test_single_frame();
    test_backpressure(1, "toggle");
    test_stall_50();
    test_continuous(1'b0, 300, "cont");
    test_start_ignored();
    test_continuous(1'b1, int'(LENGTH) + 10, "startstop");
    for (int r = 0; r < 2; r++) test_backpressure(2, "random");
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
